// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared types and helpers for the chunked sequential adder.
//   adder_state_t - IDLE / CALC / DONE controller states
//   idx_width()   - width of a counter that indexes n chunks (never below 1)
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    // A plain $clog2 gives 0 for n == 1, which would make a zero-width
    // counter. Clamp the result to at least one bit.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple slice.
//   a, b  - chunk operands
//   cin   - carry into the slice
//   s     - chunk sum
//   cout  - carry out of the slice
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/seq_adder_chunked.sv
// seq_adder_chunked: WIDTH-bit add/subtract processed CHUNK bits per clock,
// the carry rippling through a register between cycles.
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready  - operand handshake (ready only while idle)
//   a, b, cin, sub       - operands; sub=1 computes a - b - cin
//   out_valid/out_ready  - result handshake
//   sum, cout, ovf       - result, final carry (no-borrow when subtracting),
//                          signed overflow
//   busy                 - operation in progress or result pending
module seq_adder_chunked
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    adder_state_t   state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;   // already inverted when subtracting
    logic             carry_reg, carry_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    // Operands viewed as chunk arrays so the active chunk is a simple index.
    logic [CHUNK-1:0] a_chunk [NCHUNK];
    logic [CHUNK-1:0] b_chunk [NCHUNK];

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_split
            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    logic [CHUNK-1:0] chunk_s;
    logic             chunk_c;

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (a_chunk[idx_reg]),
        .b    (b_chunk[idx_reg]),
        .cin  (carry_reg),
        .s    (chunk_s),
        .cout (chunk_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            carry_reg <= carry_next;
            idx_reg   <= idx_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        carry_next = carry_reg;
        idx_next   = idx_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;

        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1; a borrow-in removes the +1.
                    a_next     = a;
                    b_next     = sub ? ~b : b;
                    carry_next = cin ^ sub;
                    idx_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                sum_next[idx_reg*CHUNK +: CHUNK] = chunk_s;
                carry_next = chunk_c;
                idx_next   = idx_reg + IW'(1);
                if (idx_reg == LAST_IDX) begin
                    cout_next  = chunk_c;
                    // Top bit of the final chunk is the result sign bit.
                    ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                 (chunk_s[CHUNK-1] != a_reg[WIDTH-1]);
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_seq_adder_chunked.sv
module tb_seq_adder_chunked;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf, busy;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    seq_adder_chunked #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands once in_ready is high; returns just after the accept edge.
    task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic vs, input logic [15:0] es, input logic ec,
                         input logic eo, input bit push);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
        if (push) exp_q.push_back('{sum: es, cout: ec, ovf: eo});
        tick();
        acc_cyc = cyc;
        in_valid = 1'b0;
        $display("issue a=%04h b=%04h cin=%0d sub=%0d exp=%04h cout=%0d ovf=%0d",
                 va, vb, vc, vs, es, ec, eo);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("idle_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Monitor: one comparison set per output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                exp_t e;
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum",  {16'd0, sum}, {16'd0, e.sum});
                    chk("cout", {31'd0, cout}, {31'd0, e.cout});
                    chk("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
                    $display("result sum=%04h cout=%0d ovf=%0d (exp %04h %0d %0d)",
                             sum, cout, ovf, e.sum, e.cout, e.ovf);
                end
            end
        end
    end

    initial begin
        int lat;
        int t0;
        logic [15:0] hold_sum;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",       {16'd0, sum},       32'd0);
        chk("rst_cout_ovf",  {30'd0, cout, ovf}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        rst_n = 1'b1;
        tick();

        // Latency; operands changed mid-calculation must not matter.
        do_op(16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b1);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("calc_in_ready", {31'd0, in_ready}, 32'd0);
            chk("calc_busy",     {31'd0, busy},     32'd1);
            tick();
            lat++;
        end
        chk("latency", lat, 32'd4);
        wait_idle();

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        do_op(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b1);
        wait_idle();

        // Backpressure with an offered operand that must be ignored.
        out_ready = 1'b0;
        do_op(16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0, 1'b1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        hold_sum = sum;
        chk("bp_sum_value", {16'd0, hold_sum}, 32'h0406);
        a = 16'h1111; b = 16'h0000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_sum",  {16'd0, sum}, {16'd0, hold_sum});
            chk("bp_hold_flag", {30'd0, cout, ovf}, 32'd0);
            chk("bp_in_ready",  {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready},  32'd1);
        chk("bp_release_sum",   {16'd0, sum},       32'h0406);

        // Reset while the third chunk is pending.
        do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_sum",       {16'd0, sum},       32'd0);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        wait_idle();

        // Back-to-back with out_ready tied high.
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
        t0 = acc_cyc;
        do_op(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("b2b_spacing1", acc_cyc - t0, 32'd6);
        t0 = acc_cyc;
        do_op(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        chk("b2b_spacing2", acc_cyc - t0, 32'd6);
        wait_idle();
        tick(); tick();

        chk("queue_empty", exp_q.size(), 32'd0);
        chk("out_count",   n_out,        32'd11);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_adder_chunked.md
Name: seq_adder_chunked

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational binary adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a register between cycles. This trades latency for a short critical path.
- Provides a valid/ready handshake on the input and output sides, plus carry-in, subtract mode and signed-overflow flag.
- Used wherever wide arithmetic must close timing at full clock rate.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of compute cycles.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  synchronous active-low reset; sampled on the rising CLK edge.
- IN_VALID  input  1  operands presented.
- IN_READY  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CIN  input  1  carry-in (add) / borrow-in (subtract).
- SUB  input  1  0 = A+B+CIN; 1 = A-B-CIN.
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  consumer accepts result.
- SUM  output  WIDTH  result, modulo 2^WIDTH.
- COUT  output  1  final carry out (subtract: 1 = no borrow).
- OVF  output  1  two's-complement signed overflow.
- BUSY  output  1  high in CALC or DONE.

Behaviour:
- Reset (RST_N=0 at an edge): state IDLE; OUT_VALID=0, SUM=0, COUT=0, OVF=0, BUSY=0. IN_READY=1 from the next cycle. Reset aborts any operation in flight; a partial result is never presented.
- IN_READY = (state==IDLE), combinational from the state register.
- State machine IDLE/CALC/DONE:
  - IDLE: on IN_VALID && IN_READY at an edge, latch A, latch B' = SUB ? ~B : B, set carry = CIN ^ SUB, set chunk index = 0, go to CALC.
  - CALC: each edge computes {c, s} = A[idx] + B'[idx] + carry for chunk idx (LSB chunk first), writes s into the result register, sets carry = c, and increments idx. At the edge processing idx = NCHUNK-1, go to DONE and set OUT_VALID=1.
  - DONE: SUM, COUT and OVF stay stable while OUT_VALID=1. On OUT_VALID && OUT_READY at an edge, go to IDLE and clear OUT_VALID. SUM, COUT and OVF hold their last values afterwards.
- Latency: with the accept edge as edge 0, OUT_VALID first reads high after edge NCHUNK. With OUT_READY held high, throughput is one result per NCHUNK+2 cycles. There is no overlap: IN_READY stays low in DONE.
- Flags:
  - SUM = final result register.
  - COUT = carry out of the top chunk.
  - OVF = (A[W-1] == B'[W-1]) && (SUM[W-1] != A[W-1]), evaluated in the final chunk.
- A, B, CIN and SUB are ignored outside the accept edge; changes during CALC/DONE have no effect.
- NCHUNK=1 is legal: CALC lasts exactly one cycle.
- IN_VALID asserted in CALC/DONE is not accepted and must be held by the producer.
- OUT_READY high while OUT_VALID=0 is ignored.

Decomposition:
- Package seq_adder_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} adder_state_t.
  - Function clog2-safe index width for the chunk counter.
- Sub-module adder_chunk: combinational CHUNK-bit adder with inputs (a, b, cin) and outputs (s, cout). It is instantiated once; the top level muxes the current chunk into it.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4.
- A=0x0003, B=0x0005, SUB=0, CIN=0 -> SUM=0x0008, COUT=0, OVF=0; OUT_VALID first high after the 4th edge following accept; IN_READY=0, BUSY=1 meanwhile.
- A=0xFFFF, B=0x0001, CIN=0 -> SUM=0x0000, COUT=1, OVF=0 (carry crosses all chunk boundaries). Then A=0x7FFF, B=0x0001 -> SUM=0x8000, COUT=0, OVF=1.
- SUB=1: A=0x0005, B=0x0007, CIN=0 -> SUM=0xFFFE, COUT=0, OVF=0. Then A=0x8000, B=0x0001 -> SUM=0x7FFF, COUT=1, OVF=1. Then A=0x0010, B=0x0001, CIN=1 -> SUM=0x000E.
- Backpressure: OUT_READY low 5 cycles after OUT_VALID rises -> SUM/COUT/OVF constant and IN_READY=0. IN_VALID with A=0x1111 is ignored. Raising OUT_READY returns to IDLE after one edge, with OUT_VALID=0 and IN_READY=1.
- Reset mid-operation: RST_N=0 for one edge while idx=2 -> OUT_VALID never rises, SUM=0, IN_READY=1. A subsequent 0x1234+0x4321 gives 0x5555.
- Back-to-back: OUT_READY tied high, three operations issued as soon as IN_READY rises -> all three results correct, spacing 6 cycles, no dropped or duplicated OUT_VALID pulses.
